// File: rtl/rt_gray_pkg.sv
// rtl/rt_gray_pkg.sv - shared constants and helper functions for the Gray/binary codec pipeline
package rt_gray_pkg;

    localparam logic RT_MODE_G2B = 1'b0;
    localparam logic RT_MODE_B2G = 1'b1;

    // Pipeline depth: enough doubling shift-XOR stages to cover the word, never fewer than one.
    function automatic int rt_calc_stages(input int bit_num);
        int s;
        s = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < bit_num) begin
                s = i + 1;
            end
        end
        return (s < 1) ? 1 : s;
    endfunction

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic rt_popcnt_gt1(input logic [63:0] v);
        return |(v & (v - 64'd1));
    endfunction

endpackage

// File: rtl/rt_gray_codec_stage.sv
// rtl/rt_gray_codec_stage.sv - one shift-XOR pipeline stage covering all channels
module rt_gray_codec_stage
    import rt_gray_pkg::*;
#(
    parameter int PARAM_BIT_NUM = 4,
    parameter int PARAM_CH_NUM  = 1,
    parameter int STAGE_IDX     = 0
) (
    input  logic                                  rt_i_clk,
    input  logic                                  rt_i_rst,
    input  logic                                  i_adv,
    input  logic                                  i_valid,
    input  logic                                  i_mode,
    input  logic [PARAM_CH_NUM*PARAM_BIT_NUM-1:0] i_data,
    input  logic [PARAM_CH_NUM-1:0]               i_err,
    output logic                                  o_valid,
    output logic                                  o_mode,
    output logic [PARAM_CH_NUM*PARAM_BIT_NUM-1:0] o_data,
    output logic [PARAM_CH_NUM-1:0]               o_err
);

    localparam int SHIFT = 1 << STAGE_IDX;

    logic [PARAM_CH_NUM*PARAM_BIT_NUM-1:0] w_next;
    logic                                  r_valid;
    logic                                  r_mode;
    logic [PARAM_CH_NUM*PARAM_BIT_NUM-1:0] r_data;
    logic [PARAM_CH_NUM-1:0]               r_err;

    // Stage 0 is d ^ (d >> 1) for both modes; later stages only act on gray-to-binary words.
    genvar ch;
    generate
        for (ch = 0; ch < PARAM_CH_NUM; ch++) begin : g_ch
            logic [PARAM_BIT_NUM-1:0] w_ch;
            assign w_ch = i_data[ch*PARAM_BIT_NUM +: PARAM_BIT_NUM];
            assign w_next[ch*PARAM_BIT_NUM +: PARAM_BIT_NUM] =
                (STAGE_IDX == 0 || i_mode == RT_MODE_G2B) ? (w_ch ^ (w_ch >> SHIFT)) : w_ch;
        end
    endgenerate

    always_ff @(posedge rt_i_clk or posedge rt_i_rst) begin
        if (rt_i_rst) begin
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_data  <= '0;
            r_err   <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_mode <= i_mode;
                r_data <= w_next;
                r_err  <= i_err;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_data  = r_data;
    assign o_err   = r_err;

endmodule

// File: rtl/rt_gray_codec_pipe.sv
// rtl/rt_gray_codec_pipe.sv - pipelined multi-channel Gray/binary converter; RT_GRAY_STEP_CHK_EN enables the Gray-step checker
module rt_gray_codec_pipe
    import rt_gray_pkg::*;
#(
    parameter int PARAM_BIT_NUM = 4,
    parameter int PARAM_CH_NUM  = 1
) (
    input  logic                                  rt_i_clk,
    input  logic                                  rt_i_rst,
    input  logic                                  rt_i_valid,
    output logic                                  rt_o_ready,
    input  logic                                  rt_i_mode,
    input  logic [PARAM_CH_NUM*PARAM_BIT_NUM-1:0] rt_i_data,
    output logic                                  rt_o_valid,
    input  logic                                  rt_i_ready,
    output logic [PARAM_CH_NUM*PARAM_BIT_NUM-1:0] rt_o_data,
    output logic                                  rt_o_mode,
    output logic [PARAM_CH_NUM-1:0]               rt_o_err
);

    localparam int S = rt_calc_stages(PARAM_BIT_NUM);
    localparam int N = PARAM_CH_NUM * PARAM_BIT_NUM;

    logic                    w_adv;
    logic [PARAM_CH_NUM-1:0] w_err_in;
    logic                    w_valid [0:S];
    logic                    w_mode  [0:S];
    logic [N-1:0]            w_data  [0:S];
    logic [PARAM_CH_NUM-1:0] w_err   [0:S];

    // One global advance: the whole pipe moves or the whole pipe holds.
    assign w_adv      = !rt_o_valid | rt_i_ready;
    assign rt_o_ready = w_adv;

`ifdef RT_GRAY_STEP_CHK_EN
    logic [N-1:0]            r_last;
    logic                    r_seen;
    logic                    w_g2b_accept;

    assign w_g2b_accept = rt_i_valid & w_adv & (rt_i_mode == RT_MODE_G2B);

    genvar ch;
    generate
        for (ch = 0; ch < PARAM_CH_NUM; ch++) begin : g_chk
            assign w_err_in[ch] = r_seen & (rt_i_mode == RT_MODE_G2B) &
                rt_popcnt_gt1(64'(rt_i_data[ch*PARAM_BIT_NUM +: PARAM_BIT_NUM] ^
                                  r_last[ch*PARAM_BIT_NUM +: PARAM_BIT_NUM]));
        end
    endgenerate

    always_ff @(posedge rt_i_clk or posedge rt_i_rst) begin
        if (rt_i_rst) begin
            r_last <= '0;
            r_seen <= 1'b0;
        end else if (w_g2b_accept) begin
            r_last <= rt_i_data;
            r_seen <= 1'b1;
        end
    end
`else
    assign w_err_in = '0;
`endif

    assign w_valid[0] = rt_i_valid;
    assign w_mode[0]  = rt_i_mode;
    assign w_data[0]  = rt_i_data;
    assign w_err[0]   = w_err_in;

    genvar k;
    generate
        for (k = 0; k < S; k++) begin : g_stage
            rt_gray_codec_stage #(
                .PARAM_BIT_NUM (PARAM_BIT_NUM),
                .PARAM_CH_NUM  (PARAM_CH_NUM),
                .STAGE_IDX     (k)
            ) u_stage (
                .rt_i_clk (rt_i_clk),
                .rt_i_rst (rt_i_rst),
                .i_adv    (w_adv),
                .i_valid  (w_valid[k]),
                .i_mode   (w_mode[k]),
                .i_data   (w_data[k]),
                .i_err    (w_err[k]),
                .o_valid  (w_valid[k+1]),
                .o_mode   (w_mode[k+1]),
                .o_data   (w_data[k+1]),
                .o_err    (w_err[k+1])
            );
        end
    endgenerate

    assign rt_o_valid = w_valid[S];
    assign rt_o_mode  = w_mode[S];
    assign rt_o_data  = w_data[S];
    assign rt_o_err   = w_err[S];

endmodule
